multi_digit_bcd_display_controller: RTL and testbench

MULTI_DIGIT_BCD_DISPLAY_CONTROLLER -- requirements
Module: multi_digit_bcd_display_controller

---
 rtl/multi_digit_bcd_display_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_multi_digit_bcd_display_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_bcd_display_controller.sv
// ---------------------------------------------------------------------------
// multi_digit_bcd_display_controller
//
// Multi-digit BCD up/down counter with a time-multiplexed, active-low
// seven-segment display driver.
//
//   A prescaler divides clk_100_Mhz down to a count tick. On a tick the
//   BCD count steps up or down by one with per-digit carry/borrow. A
//   synchronous load overrides any tick in the same cycle. A separate
//   refresh counter walks the scan index across the digits, and the anode
//   and cathode outputs are registered from that index.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank every digit above the most significant
//                           nonzero digit (digit 0 is always shown).
//
// Parameters:
//   NUM_DIGITS      number of BCD digits / anodes (1..8)
//   TICK_DIVISOR    clock cycles per count tick (>= 2)
//   REFRESH_DIVISOR clock cycles per digit scan step (>= 2)
//
// Ports:
//   clk_100_Mhz                in   system clock, rising edge
//   reset                      in   asynchronous, active-high reset
//   count_enable               in   allow counting on a tick
//   count_up                   in   1 = increment, 0 = decrement
//   load                       in   synchronous load strobe
//   load_value                 in   BCD value to load, nibble 0 = LSD
//   bcd_digits                 out  current count, nibble 0 = LSD
//   rollover                   out  one-cycle pulse after a count wrap
//   anode_bits                 out  active-low digit select, bit i = digit i
//   seven_segments_LED_output  out  active-low cathodes, bit 6 = a .. bit 0 = g
// ---------------------------------------------------------------------------
module multi_digit_bcd_display_controller #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_DIVISOR    = 100_000_000,
  parameter int REFRESH_DIVISOR = 100_000
) (
  input  logic                    clk_100_Mhz,
  input  logic                    reset,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd_digits,
  output logic                    rollover,
  output logic [NUM_DIGITS-1:0]   anode_bits,
  output logic [6:0]              seven_segments_LED_output
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int TICK_W = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
  localparam int REF_W  = (REFRESH_DIVISOR > 1) ? $clog2(REFRESH_DIVISOR) : 1;
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    DISP_BLANK,
    DISP_SCAN
  } disp_state_t;

  // -------------------------------------------------------------------------
  // Segment decode (active low, bit 6 = a ... bit 0 = g)
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;

  logic [DW-1:0]         count_q;
  logic [DW-1:0]         step_value;
  logic                  step_wrap;
  logic [DW-1:0]         load_clean;
  logic [3:0]            digit_tmp;
  logic                  carry;

  logic [REF_W-1:0]      refresh_cnt;
  logic                  refresh_tc;
  logic [SCAN_W-1:0]     scan_idx;

  logic [3:0]            sel_digit;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] blank_mask;

  disp_state_t           state_q;
  disp_state_t           state_d;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [6:0]            seg_d;

  assign bcd_digits = count_q;

  // -------------------------------------------------------------------------
  // Tick prescaler: free-running, independent of count_enable and load
  // -------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_W'(TICK_DIVISOR - 1));

  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // BCD step: ripple carry/borrow from the least significant digit. A carry
  // out of the top digit means the count wrapped (all-9s <-> all-0s).
  // -------------------------------------------------------------------------
  always_comb begin
    step_value = count_q;
    carry      = 1'b1;
    digit_tmp  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_tmp = count_q[4*i +: 4];
      if (carry) begin
        if (count_up) begin
          if (digit_tmp >= 4'd9) begin
            digit_tmp = 4'd0;
          end else begin
            digit_tmp = digit_tmp + 4'd1;
            carry     = 1'b0;
          end
        end else begin
          if (digit_tmp == 4'd0) begin
            digit_tmp = 4'd9;
          end else begin
            digit_tmp = digit_tmp - 4'd1;
            carry     = 1'b0;
          end
        end
      end
      step_value[4*i +: 4] = digit_tmp;
    end
    step_wrap = carry;
  end

  // Non-BCD nibbles in the load value are forced to zero
  always_comb begin
    load_clean = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
    end
  end

  // -------------------------------------------------------------------------
  // Count register and rollover pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rollover <= 1'b0;
    end else if (load) begin
      count_q  <= load_clean;
      rollover <= 1'b0;
    end else if (tick && count_enable) begin
      count_q  <= step_value;
      rollover <= step_wrap;
    end else begin
      rollover <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Refresh counter and scan index
  // -------------------------------------------------------------------------
  assign refresh_tc = (refresh_cnt == REF_W'(REFRESH_DIVISOR - 1));

  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
    end else if (refresh_tc) begin
      if (scan_idx == SCAN_W'(NUM_DIGITS - 1)) begin
        scan_idx <= '0;
      end else begin
        scan_idx <= scan_idx + SCAN_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero blanking mask: digit i blanks when it and every digit
  // above it are zero. Digit 0 never blanks.
  // -------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
      upper_zero = upper_zero & (count_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      blank_mask[NUM_DIGITS-1-k] = upper_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Digit and blank flag currently selected by the scan index
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == SCAN_W'(i)) begin
        sel_digit = count_q[4*i +: 4];
        sel_blank = blank_mask[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Display FSM: one blank cycle after reset release so the first anode
  // selection lands on the second rising edge, then continuous scanning.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      state_q <= DISP_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    anode_d = '1;
    seg_d   = 7'b1111111;
    case (state_q)
      DISP_BLANK: begin
        state_d = DISP_SCAN;
      end
      DISP_SCAN: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          anode_d[i] = (scan_idx != SCAN_W'(i));
        end
        seg_d = sel_blank ? 7'b1111111 : seg_decode(sel_digit);
      end
      default: begin
        state_d = DISP_BLANK;
      end
    endcase
  end

  // Registered display outputs, anode and cathodes aligned
  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      anode_bits                <= '1;
      seven_segments_LED_output <= 7'b1111111;
    end else begin
      anode_bits                <= anode_d;
      seven_segments_LED_output <= seg_d;
    end
  end

endmodule

// File: tb/tb_multi_digit_bcd_display_controller.sv
// ---------------------------------------------------------------------------
// Testbench for multi_digit_bcd_display_controller (NUM_DIGITS=4,
// TICK_DIVISOR=2, REFRESH_DIVISOR=4).
//
// A reference model keeps the count as a plain integer and derives the
// scan position from the number of clock edges since reset release. Each
// rising edge it pushes the expected outputs into a queue; a monitor pops
// and compares on the falling edge. Directed scenarios add a few spot
// checks against constant values.
// ---------------------------------------------------------------------------
module tb_multi_digit_bcd_display_controller;

  localparam int N = 4;
  localparam int T = 2;
  localparam int R = 4;

  typedef struct {
    logic [4*N-1:0] bcd;
    logic           roll;
    logic [N-1:0]   an;
    logic [6:0]     seg;
  } exp_t;

  logic           clk_100_Mhz = 1'b0;
  logic           reset;
  logic           count_enable;
  logic           count_up;
  logic           load;
  logic [4*N-1:0] load_value;
  logic [4*N-1:0] bcd_digits;
  logic           rollover;
  logic [N-1:0]   anode_bits;
  logic [6:0]     seven_segments_LED_output;

  int unsigned n_compared = 0;
  int unsigned n_mismatch = 0;

  exp_t        exp_q[$];
  int unsigned edge_k = 0;
  int unsigned cnt    = 0;

  multi_digit_bcd_display_controller #(
    .NUM_DIGITS     (N),
    .TICK_DIVISOR   (T),
    .REFRESH_DIVISOR(R)
  ) dut (
    .clk_100_Mhz              (clk_100_Mhz),
    .reset                    (reset),
    .count_enable             (count_enable),
    .count_up                 (count_up),
    .load                     (load),
    .load_value               (load_value),
    .bcd_digits               (bcd_digits),
    .rollover                 (rollover),
    .anode_bits               (anode_bits),
    .seven_segments_LED_output(seven_segments_LED_output)
  );

  always #5 clk_100_Mhz = ~clk_100_Mhz;

  // ---------------- reference helpers ----------------
  function automatic int unsigned pow10(input int unsigned e);
    int unsigned p = 1;
    for (int unsigned i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int unsigned v);
    logic [4*N-1:0] r = '0;
    for (int unsigned i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int unsigned load_to_int(input logic [4*N-1:0] lv);
    int unsigned v = 0;
    for (int unsigned i = 0; i < N; i++)
      if (lv[4*i +: 4] <= 4'd9) v = v + int'(lv[4*i +: 4]) * pow10(i);
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  initial begin
    exp_t        e;
    int unsigned idx;
    int unsigned modv;
    bit          blank;
    modv = pow10(N);
    forever begin
      @(posedge clk_100_Mhz);
      if (reset) begin
        edge_k = 0;
        cnt    = 0;
      end else begin
        edge_k++;
        // display outputs reflect the scan position and count before this edge
        if (edge_k >= 2) begin
          idx   = ((edge_k - 1) / R) % N;
          e.an  = '1;
          e.an[idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          blank = (idx > 0) && (cnt < pow10(idx));
`else
          blank = 1'b0;
`endif
          e.seg = blank ? 7'b1111111 : seg_of((cnt / pow10(idx)) % 10);
        end else begin
          e.an  = '1;
          e.seg = 7'b1111111;
        end
        e.roll = 1'b0;
        if (load) begin
          cnt = load_to_int(load_value);
        end else if ((edge_k % T == 0) && count_enable) begin
          if (count_up) begin
            e.roll = (cnt == modv - 1);
            cnt    = (cnt + 1) % modv;
          end else begin
            e.roll = (cnt == 0);
            cnt    = (cnt + modv - 1) % modv;
          end
        end
        e.bcd = to_bcd(cnt);
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100_Mhz);
      if (exp_q.size() > 1) begin
        check("queue_depth", 32'(exp_q.size()), 32'd1);
      end
      if (reset || exp_q.size() == 0) begin
        exp_q.delete();
        check("rst_bcd",   32'(bcd_digits), 32'h0);
        check("rst_roll",  32'(rollover), 32'h0);
        check("rst_anode", 32'(anode_bits), 32'hF);
        check("rst_seg",   32'(seven_segments_LED_output), 32'h7F);
      end else begin
        e = exp_q.pop_front();
        check("bcd",   32'(bcd_digits), 32'(e.bcd));
        check("roll",  32'(rollover), 32'(e.roll));
        check("anode", 32'(anode_bits), 32'(e.an));
        check("seg",   32'(seven_segments_LED_output), 32'(e.seg));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk_100_Mhz);
      #1;
    end
  endtask

  // return when the next rising edge will be a count tick
  task automatic wait_pre_tick();
    for (int unsigned i = 0; i < T && (edge_k % T) != T - 1; i++) step(1);
  endtask

  initial begin
    reset        = 1'b1;
    count_enable = 1'b0;
    count_up     = 1'b1;
    load         = 1'b0;
    load_value   = '0;
    step(3);
    reset = 1'b0;

    // count up from reset
    count_enable = 1'b1;
    count_up     = 1'b1;
    step(20);
    check("up20_bcd",  32'(bcd_digits), 32'h0010);
    check("up20_roll", 32'(rollover), 32'h0);

    // wrap upward from 9998
    load = 1'b1; load_value = 16'h9998; step(1); load = 1'b0;
    wait_pre_tick();
    step(1);
    check("up_9999", 32'(bcd_digits), 32'h9999);
    step(T);
    check("up_wrap_bcd",  32'(bcd_digits), 32'h0000);
    check("up_wrap_roll", 32'(rollover), 32'h1);
    step(1);
    check("up_wrap_roll_end", 32'(rollover), 32'h0);

    // wrap downward from 0000, then load with invalid nibbles
    count_up = 1'b0;
    load = 1'b1; load_value = 16'h0000; step(1); load = 1'b0;
    wait_pre_tick();
    step(1);
    check("dn_wrap_bcd",  32'(bcd_digits), 32'h9999);
    check("dn_wrap_roll", 32'(rollover), 32'h1);
    load = 1'b1; load_value = 16'h12AF; step(1); load = 1'b0;
    check("load_sanit", 32'(bcd_digits), 32'h1200);
    check("load_roll",  32'(rollover), 32'h0);

    // load coincident with a tick wins
    count_up = 1'b1;
    wait_pre_tick();
    load = 1'b1; load_value = 16'h0042; step(1); load = 1'b0;
    check("load_vs_tick", 32'(bcd_digits), 32'h0042);

    // hold 0305 and watch a full scan
    count_enable = 1'b0;
    load = 1'b1; load_value = 16'h0305; step(1); load = 1'b0;
    step(16);
    check("hold_0305", 32'(bcd_digits), 32'h0305);

    // reset mid-scan / mid-count
    count_enable = 1'b1;
    load = 1'b1; load_value = 16'h0777; step(1); load = 1'b0;
    step(5);
    reset = 1'b1;
    #1;
    check("async_bcd",   32'(bcd_digits), 32'h0);
    check("async_anode", 32'(anode_bits), 32'hF);
    check("async_seg",   32'(seven_segments_LED_output), 32'h7F);
    check("async_roll",  32'(rollover), 32'h0);
    step(2);
    reset = 1'b0;
    step(20);
    check("restart_bcd", 32'(bcd_digits), 32'h0010);

    // randomized traffic with biased boundary loads
    repeat (600) begin
      count_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) count_up = ~count_up;
      load = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 4))
        0:       load_value = 16'h9999;
        1:       load_value = 16'h0000;
        2:       load_value = 16'h9998;
        3:       load_value = 16'h0001;
        default: load_value = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0;
    load  = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_compared, n_mismatch);
    $fatal(1, "watchdog");
  end

endmodule
